mult_result_bcd: RTL and testbench
==================================

Name: mult_result_bcd

Overview:
- Downstream consumer of the 4x4 shift-add multiplier: watches the multiplier's ready line and captures the 9-bit product on each completion.
- Converts the captured product to three packed BCD digits with a sequential double-dabble engine, for display or reporting logic.
- Handshake uses only the multiplier's existing outputs (result, ready). No changes to the multiplier are needed.

Parameters:
- WIDTH, 9, binary input width; equals multiplier result width.
- CNT_W, 4, shift-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mult_result  input  WIDTH  product from multiplier; sampled only on the capture edge.
- mult_ready  input  1  multiplier ready line; a 0->1 transition means a new product is available.
- clr_overrun  input  1  synchronous clear of the overrun flag.
- bcd_hundreds  output  4  hundreds digit of last completed conversion.
- bcd_tens  output  4  tens digit.
- bcd_ones  output  4  ones digit.
- done  output  1  one-cycle pulse; new digits valid.
- busy  output  1  high while a conversion is in progress.
- overrun  output  1  sticky; a product arrived while busy and was dropped.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; digits=0; done=0; busy=0; overrun=0.
  - ready_q=1, so a mult_ready already high after reset does not trigger a capture.
- Edge detect: ready_q registers mult_ready every cycle. rise = mult_ready & ~ready_q.
- State IDLE:
  - On rise: load shift_reg=mult_result, clear the 12-bit digit accumulator, cnt=0, go to SHIFT. Call this edge E0.
  - Otherwise hold.
- State SHIFT (one step per cycle):
  - Add 3 to each accumulator nibble that is >=5.
  - Then shift {acc, shift_reg} left by 1 and increment cnt.
  - At the step where cnt reaches WIDTH (edge E9 for WIDTH=9), go to DONE.
- State DONE (edge E10):
  - Copy the accumulator to bcd_hundreds/tens/ones; done=1; go to IDLE.
  - done returns to 0 at E11.
- Latency: done rises at edge E0+WIDTH+1, i.e. 10 clocks after capture.
- busy = (state != IDLE): high from E0 through the cycle ending at E10.
- Output hold: digits keep their value until the next DONE. They never show intermediate values.
- Range: inputs up to 2^WIDTH-1 (511) convert correctly. A 4x4 product is at most 225.
- Rise while state != IDLE (including the DONE cycle):
  - The product is dropped and overrun is set to 1.
  - The conversion in progress is unaffected.
- Overrun clearing:
  - clr_overrun=1 clears overrun on the next edge.
  - If clr_overrun coincides with a new dropped rise, the set wins.
- mult_ready held high for many cycles: exactly one capture. A new capture needs ready to fall and rise again.
- Reset mid-conversion: aborts immediately, outputs return to reset values, no done pulse.
  - After release, a product is captured only on a fresh 0->1 of mult_ready.

Test Plan:
- Chained with the multiplier, reset for 30 time units, start with a=11, b=9 -> product 99 captured; done pulses 10 clocks after the ready rise; digits 0/9/9; overrun=0.
- Direct drive: mult_result=0 with a ready pulse -> digits 0/0/0, done one cycle. Then mult_result=511 -> 5/1/1. Then 225 -> 2/2/5, earlier digits held until each done.
- mult_ready high through reset and after release, no transition -> no capture, busy=0, done never asserts, digits stay 0.
- Second ready rise 4 clocks after the first (value 37 then 200) -> first conversion completes with 0/3/7; 200 dropped; overrun=1 and stays 1; clr_overrun pulse -> overrun=0.
- Reset asserted 5 clocks into converting 123 -> busy=0, digits 0, no done. After release, ready rise with 45 -> 0/4/5 after 10 clocks.
- Ready rise during the DONE cycle of a conversion of 88 -> 0/8/8 delivered, new value dropped, overrun=1.

Source files
------------

// File: rtl/mult_result_bcd.sv
// Captures a multiplier product on each ready rise and converts it to
// three packed BCD digits with a sequential double-dabble engine.
module mult_result_bcd #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mult_result,
  input  logic             mult_ready,
  input  logic             clr_overrun,
  output logic [3:0]       bcd_hundreds,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             done,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_ready_q;
  logic             w_rise;
  logic             w_last;
  logic [WIDTH-1:0] r_shift;
  logic [11:0]      r_acc;
  logic [11:0]      w_adj;
  logic [CNT_W-1:0] r_cnt;
  logic [11:0]      r_digits;
  logic             r_done;
  logic             r_ovr;

  assign w_rise = mult_ready & ~r_ready_q;
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < 3; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_rise) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Ready_q resets high so a ready already asserted is not a rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready_q <= 1'b1;
      r_shift   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_digits  <= '0;
      r_done    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_ready_q <= mult_ready;
      r_done    <= (r_state == S_DONE);
      if (w_rise && r_state != S_IDLE) r_ovr <= 1'b1;
      else if (clr_overrun)            r_ovr <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_shift <= mult_result;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_SHIFT: begin
          {r_acc, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE:  r_digits <= r_acc;
        default: ;
      endcase
    end
  end

  assign bcd_hundreds = r_digits[11:8];
  assign bcd_tens     = r_digits[7:4];
  assign bcd_ones     = r_digits[3:0];
  assign done         = r_done;
  assign overrun      = r_ovr;

endmodule

// File: tb/tb_mult_result_bcd.sv
// Directed bench for mult_result_bcd: latency, digits, overrun, reset.
module tb_mult_result_bcd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] mult_result = '0;
  logic       mult_ready = 1'b0;
  logic       clr_overrun = 1'b0;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       done;
  logic       busy;
  logic       overrun;

  int n_tests = 0;
  int n_fail = 0;

  mult_result_bcd #(.WIDTH(9), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .mult_result(mult_result),
    .mult_ready(mult_ready),
    .clr_overrun(clr_overrun),
    .bcd_hundreds(bcd_hundreds),
    .bcd_tens(bcd_tens),
    .bcd_ones(bcd_ones),
    .done(done),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] digs();
    return {bcd_hundreds, bcd_tens, bcd_ones};
  endfunction

  // Raise ready for one cycle with a product; returns at negedge after E0.
  task automatic start(input logic [8:0] v);
    mult_result = v;
    mult_ready  = 1'b1;
    @(negedge clk);
    mult_ready  = 1'b0;
  endtask

  // Counts negedges since the ready rise until done is seen (bounded).
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({digs(), done, busy, overrun} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_state: got %h/%b/%b/%b want 000/0/0/0",
               digs(), done, busy, overrun);
    end
    #28;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_99();
    int n;
    start(9'd99);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_99: got %b want 1", busy);
    end
    wait_done(1, n);
    n_tests++;
    if (n != 11) begin
      n_fail++;
      $display("FAIL latency_99: got %0d want 11", n);
    end
    n_tests++;
    if (digs() !== 12'h099 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL digits_99: got %h ovr %b want 099 ovr 0",
               digs(), overrun);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_99: got done %b busy %b want 0 0",
               done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_direct();
    int n;
    logic [8:0]  vin  [3] = '{9'd0, 9'd511, 9'd225};
    logic [11:0] vexp [3] = '{12'h000, 12'h511, 12'h225};
    logic [11:0] prev;
    prev = 12'h099;
    for (int i = 0; i < 3; i++) begin
      start(vin[i]);
      repeat (5) @(negedge clk);
      n_tests++;
      if (digs() !== prev) begin
        n_fail++;
        $display("FAIL hold_%0d: got %h want %h", i, digs(), prev);
      end
      wait_done(6, n);
      n_tests++;
      if (n != 11 || digs() !== vexp[i]) begin
        n_fail++;
        $display("FAIL direct_%0d: got %h at %0d want %h at 11",
                 i, digs(), n, vexp[i]);
      end
      prev = vexp[i];
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_ready_held();
    int bad;
    bad = 0;
    mult_result = 9'd77;
    mult_ready  = 1'b1;
    reset       = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    n_tests++;
    if (bad != 0 || digs() !== 12'h000) begin
      n_fail++;
      $display("FAIL ready_held: got %0d active cycles digits %h want 0 000",
               bad, digs());
    end
    mult_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_overrun();
    int n;
    start(9'd37);
    repeat (3) @(negedge clk);
    start(9'd200);
    wait_done(5, n);
    n_tests++;
    if (n != 11 || digs() !== 12'h037 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_37: got %h at %0d ovr %b want 037 at 11 ovr 1",
               digs(), n, overrun);
    end
    repeat (5) @(negedge clk);
    n_tests++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_sticky: got ovr %b busy %b want 1 0",
               overrun, busy);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b want 0", overrun);
    end
    start(9'd50);
    @(negedge clk);
    clr_overrun = 1'b1;
    start(9'd99);
    clr_overrun = 1'b0;
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set_wins: got %b want 1", overrun);
    end
    wait_done(3, n);
    n_tests++;
    if (digs() !== 12'h050) begin
      n_fail++;
      $display("FAIL overrun_50: got %h want 050", digs());
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    start(9'd123);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({digs(), done, busy, overrun} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h/%b/%b/%b want 000/0/0/0",
               digs(), done, busy, overrun);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d active cycles want 0", bad);
    end
    start(9'd45);
    wait_done(1, n);
    n_tests++;
    if (n != 11 || digs() !== 12'h045) begin
      n_fail++;
      $display("FAIL after_reset_45: got %h at %0d want 045 at 11",
               digs(), n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_done_cycle_rise();
    start(9'd88);
    repeat (9) @(negedge clk);
    mult_result = 9'd77;
    mult_ready  = 1'b1;
    @(negedge clk);
    mult_ready  = 1'b0;
    n_tests++;
    if (done !== 1'b1 || digs() !== 12'h088 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL done_cycle: got done %b %h ovr %b want 1 088 1",
               done, digs(), overrun);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || digs() !== 12'h088) begin
      n_fail++;
      $display("FAIL done_cycle_drop: got busy %b %h want 0 088",
               busy, digs());
    end
  endtask

  initial begin
    test_reset();
    test_basic_99();
    test_direct();
    test_ready_held();
    test_overrun();
    test_reset_mid();
    test_done_cycle_rise();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
